// File: rtl/ant_step_scheduler.sv
// ============================================================================
// Module   : ant_step_scheduler
// Brief    : Serial ant setup loader and timed step sequencer (move strobe,
//            then a write sweep over a snapshot of all ant positions).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ant_step_scheduler #(
  parameter int ANT_num  = 8,
  parameter int X_bits   = 8,
  parameter int Y_bits   = 7,
  parameter int Ant_bits = 16,
  parameter int ID_bits  = (ANT_num > 1) ? $clog2(ANT_num) : 1
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET_SIM_N,
  input  logic                        start_setup,
  input  logic                        run_en,
  input  logic [15:0]                 step_period,
  input  logic                        cfg_valid,
  input  logic [Ant_bits-1:0]         cfg_data,
  output logic                        cfg_ready,
  input  logic [ANT_num*X_bits-1:0]   Ant_X,
  input  logic [ANT_num*Y_bits-1:0]   Ant_Y,
  output logic                        SETUP_MODE,
  output logic                        setup_clk,
  output logic [ID_bits-1:0]          ant_id,
  output logic [Ant_bits-1:0]         ant_data,
  output logic                        newLocClock,
  output logic                        write_flag,
  output logic [X_bits-1:0]           writeLoc_x,
  output logic [Y_bits-1:0]           writeLoc_y,
  output logic                        setup_done,
  output logic [15:0]                 step_count
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_CFG_WAIT = 3'd1;
  localparam logic [2:0] c_CFG_LOAD = 3'd2;
  localparam logic [2:0] c_CFG_NEXT = 3'd3;
  localparam logic [2:0] c_RUN_WAIT = 3'd4;
  localparam logic [2:0] c_MOVE     = 3'd5;
  localparam logic [2:0] c_SETTLE   = 3'd6;
  localparam logic [2:0] c_WRITE    = 3'd7;

  localparam logic [ID_bits-1:0] c_LAST_ID = ID_bits'(ANT_num - 1);

  logic [2:0]                  r_state, w_next;
  logic [15:0]                 r_counter, w_counter_n, w_target;
  logic [ID_bits-1:0]          r_idx, w_idx_n;
  logic [ANT_num*X_bits-1:0]   r_snap_x, w_snap_x_n;
  logic [ANT_num*Y_bits-1:0]   r_snap_y, w_snap_y_n;
  logic [ID_bits-1:0]          r_ant_id, w_ant_id_n;
  logic [Ant_bits-1:0]         r_ant_data, w_ant_data_n;
  logic                        r_setup_mode, w_setup_mode_n;
  logic                        r_setup_done, w_setup_done_n;
  logic [15:0]                 r_step_count, w_step_count_n;
  logic [X_bits-1:0]           r_loc_x, w_loc_x_n;
  logic [Y_bits-1:0]           r_loc_y, w_loc_y_n;
  logic                        r_cfg_ready, r_setup_clk, r_new_loc, r_write_flag;

  // A zero period would never match a counter starting at 0; run it as 1.
  assign w_target = (step_period == 16'd0) ? 16'd0 : step_period - 16'd1;

  // Strobes are registered decodes of the next state, so each is high for
  // exactly the cycle the FSM spends in the matching state.
  always_ff @(posedge CLOCK_50 or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      r_state      <= c_IDLE;
      r_counter    <= '0;
      r_idx        <= '0;
      r_snap_x     <= '0;
      r_snap_y     <= '0;
      r_ant_id     <= '0;
      r_ant_data   <= '0;
      r_setup_mode <= 1'b0;
      r_setup_done <= 1'b0;
      r_step_count <= '0;
      r_loc_x      <= '0;
      r_loc_y      <= '0;
      r_cfg_ready  <= 1'b0;
      r_setup_clk  <= 1'b0;
      r_new_loc    <= 1'b0;
      r_write_flag <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_counter    <= w_counter_n;
      r_idx        <= w_idx_n;
      r_snap_x     <= w_snap_x_n;
      r_snap_y     <= w_snap_y_n;
      r_ant_id     <= w_ant_id_n;
      r_ant_data   <= w_ant_data_n;
      r_setup_mode <= w_setup_mode_n;
      r_setup_done <= w_setup_done_n;
      r_step_count <= w_step_count_n;
      r_loc_x      <= w_loc_x_n;
      r_loc_y      <= w_loc_y_n;
      r_cfg_ready  <= (w_next == c_CFG_WAIT);
      r_setup_clk  <= (w_next == c_CFG_LOAD);
      r_new_loc    <= (w_next == c_MOVE);
      r_write_flag <= (w_next == c_WRITE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (start_setup)                 w_next = c_CFG_WAIT;
        else if (r_setup_done && run_en) w_next = c_RUN_WAIT;
      end
      c_CFG_WAIT: if (cfg_valid && r_cfg_ready) w_next = c_CFG_LOAD;
      c_CFG_LOAD: w_next = c_CFG_NEXT;
      c_CFG_NEXT: w_next = (r_ant_id == c_LAST_ID) ? c_IDLE : c_CFG_WAIT;
      c_RUN_WAIT: begin
        if (start_setup)                         w_next = c_CFG_WAIT;
        else if (run_en && r_counter >= w_target) w_next = c_MOVE;
      end
      c_MOVE:   w_next = c_SETTLE;
      c_SETTLE: w_next = c_WRITE;
      c_WRITE:  w_next = (r_idx == c_LAST_ID) ? c_RUN_WAIT : c_WRITE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_counter_n    = r_counter;
    w_idx_n        = r_idx;
    w_snap_x_n     = r_snap_x;
    w_snap_y_n     = r_snap_y;
    w_ant_id_n     = r_ant_id;
    w_ant_data_n   = r_ant_data;
    w_setup_mode_n = r_setup_mode;
    w_setup_done_n = r_setup_done;
    w_step_count_n = r_step_count;
    w_loc_x_n      = '0;
    w_loc_y_n      = '0;
    case (r_state)
      c_IDLE, c_RUN_WAIT: begin
        if (w_next == c_CFG_WAIT) begin
          w_ant_id_n     = '0;
          w_setup_mode_n = 1'b1;
          w_setup_done_n = 1'b0;
        end else if (r_state == c_IDLE && w_next == c_RUN_WAIT) begin
          w_counter_n = '0;
        end else if (r_state == c_RUN_WAIT && w_next == c_RUN_WAIT && run_en) begin
          w_counter_n = r_counter + 16'd1;
        end
      end
      c_CFG_WAIT: if (w_next == c_CFG_LOAD) w_ant_data_n = cfg_data;
      c_CFG_NEXT: begin
        if (r_ant_id == c_LAST_ID) begin
          w_ant_id_n     = '0;
          w_setup_mode_n = 1'b0;
          w_setup_done_n = 1'b1;
        end else begin
          w_ant_id_n = r_ant_id + 1'b1;
        end
      end
      c_SETTLE: begin
        w_snap_x_n = Ant_X;
        w_snap_y_n = Ant_Y;
        w_idx_n    = '0;
      end
      c_WRITE: begin
        if (w_next == c_RUN_WAIT) begin
          w_step_count_n = r_step_count + 16'd1;
          w_counter_n    = '0;
        end else begin
          w_idx_n = r_idx + 1'b1;
        end
      end
      default: ;
    endcase
    // Select from the next snapshot so slot 0 lines up with the first write cycle.
    if (w_next == c_WRITE) begin
      for (int i = 0; i < ANT_num; i++) begin
        if (w_idx_n == ID_bits'(i)) begin
          w_loc_x_n = w_snap_x_n[i*X_bits +: X_bits];
          w_loc_y_n = w_snap_y_n[i*Y_bits +: Y_bits];
        end
      end
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign SETUP_MODE  = r_setup_mode;
  assign setup_clk   = r_setup_clk;
  assign ant_id      = r_ant_id;
  assign ant_data    = r_ant_data;
  assign newLocClock = r_new_loc;
  assign write_flag  = r_write_flag;
  assign writeLoc_x  = r_loc_x;
  assign writeLoc_y  = r_loc_y;
  assign setup_done  = r_setup_done;
  assign step_count  = r_step_count;

endmodule

`default_nettype wire

// File: tb/tb_ant_step_scheduler.sv
// ============================================================================
// Module   : tb_ant_step_scheduler
// Brief    : Directed vector bench for ant_step_scheduler with four ants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ant_step_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_setup, run_en, cfg_valid, cfg_ready;
  logic [15:0] step_period, cfg_data;
  logic [31:0] Ant_X;
  logic [27:0] Ant_Y;
  logic        SETUP_MODE, setup_clk, newLocClock, write_flag, setup_done;
  logic [1:0]  ant_id;
  logic [15:0] ant_data, step_count;
  logic [7:0]  writeLoc_x;
  logic [6:0]  writeLoc_y;

  int n_vec = 0;
  int n_err = 0;

  ant_step_scheduler #(.ANT_num(4), .X_bits(8), .Y_bits(7), .Ant_bits(16)) dut (
    .CLOCK_50(clk), .RESET_SIM_N(rst_n), .start_setup(start_setup), .run_en(run_en),
    .step_period(step_period), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .Ant_X(Ant_X), .Ant_Y(Ant_Y), .SETUP_MODE(SETUP_MODE),
    .setup_clk(setup_clk), .ant_id(ant_id), .ant_data(ant_data),
    .newLocClock(newLocClock), .write_flag(write_flag), .writeLoc_x(writeLoc_x),
    .writeLoc_y(writeLoc_y), .setup_done(setup_done), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, vld;
    logic [15:0] dat;
    logic        rdy, sclk;
    logic [1:0]  id;
    logic [15:0] adat;
    logic        mode, done;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {cfg_ready, SETUP_MODE, setup_clk, ant_id, ant_data, newLocClock,
            write_flag, writeLoc_x, writeLoc_y, setup_done, step_count};
  endfunction

  task automatic wait_nlc(input int max, input int exp_n, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!newLocClock && n < max);
    chk(name, {47'd0, newLocClock, n[15:0]}, {47'd0, 1'b1, exp_n[15:0]});
  endtask

  // mode 1: disturb Ant_X after first slot; mode 2: drop run_en mid-sweep
  task automatic check_sweep(input logic [31:0] ex, input logic [27:0] ey, input int mode);
    tick();
    chk("settle", {newLocClock, write_flag, setup_clk}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("write_slot", {write_flag, newLocClock, setup_clk, SETUP_MODE, writeLoc_x, writeLoc_y},
          {1'b1, 1'b0, 1'b0, 1'b0, ex[i*8 +: 8], ey[i*7 +: 7]});
      if (mode == 1 && i == 0) Ant_X = ~Ant_X;
      if (mode == 2 && i == 1) run_en = 1'b0;
    end
    tick();
    chk("write_end", {newLocClock, write_flag}, 2'b00);
  endtask

  task automatic quick_setup();
    int n = 0;
    start_setup = 1'b1;
    tick();
    start_setup = 1'b0;
    cfg_valid   = 1'b1;
    cfg_data    = 16'h0055;
    do begin
      tick();
      n++;
    end while (!setup_done && n < 40);
    cfg_valid = 1'b0;
    chk("quick_setup", {SETUP_MODE, setup_done}, 2'b01);
  endtask

  localparam logic [31:0] c_AX = {8'd9, 8'd6, 8'd3, 8'd0};
  localparam logic [27:0] c_AY = {7'd4, 7'd3, 7'd2, 7'd1};

  initial begin
    logic [31:0] ax_alt;
    int          seen;
    //         st    vld   dat       rdy   sclk  id    adat      mode  done
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h1000, 1'b0, 1'b1, 2'd0, 16'h1000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 2'd0, 16'h1000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'h1001, 1'b1, 1'b0, 2'd1, 16'h1000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'h1001, 1'b0, 1'b1, 2'd1, 16'h1001, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 2'd1, 16'h1001, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h1002, 1'b1, 1'b0, 2'd2, 16'h1001, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h1002, 1'b0, 1'b1, 2'd2, 16'h1002, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'h1002, 1'b0, 1'b0, 2'd2, 16'h1002, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h1003, 1'b1, 1'b0, 2'd3, 16'h1002, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h1003, 1'b0, 1'b1, 2'd3, 16'h1003, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 16'h1003, 1'b0, 1'b0, 2'd3, 16'h1003, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h1003, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h1003, 1'b0, 1'b1};

    rst_n = 1'b0; start_setup = 1'b0; run_en = 1'b0; step_period = 16'd10;
    cfg_valid = 1'b0; cfg_data = 16'h0; Ant_X = c_AX; Ant_Y = c_AY;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", all_outs(), 64'd0);
    #3 rst_n = 1'b1;

    // Setup with cfg_valid held high
    for (int k = 0; k < 14; k++) begin
      start_setup = tbl[k].st;
      cfg_valid   = tbl[k].vld;
      cfg_data    = tbl[k].dat;
      tick();
      chk($sformatf("setup_vec%0d", k),
          {cfg_ready, setup_clk, ant_id, ant_data, SETUP_MODE, setup_done, newLocClock, write_flag},
          {tbl[k].rdy, tbl[k].sclk, tbl[k].id, tbl[k].adat, tbl[k].mode, tbl[k].done, 2'b00});
    end

    // Setup with cfg_valid stalled 5 cycles per ant
    start_setup = 1'b1;
    tick();
    start_setup = 1'b0;
    for (int a = 0; a < 4; a++) begin
      seen = 0;
      cfg_valid = 1'b0;
      for (int s = 0; s < 5; s++) begin
        tick();
        if (!cfg_ready || setup_clk || ant_id != 2'(a) || setup_done || !SETUP_MODE) seen++;
      end
      chk("stall_hold", seen[15:0], 16'd0);
      cfg_valid = 1'b1;
      cfg_data  = 16'h2A00 + 16'(a * 17);
      tick();
      chk("stall_load", {setup_clk, ant_id, ant_data}, {1'b1, 2'(a), 16'h2A00 + 16'(a * 17)});
      cfg_valid = 1'b0;
      tick();
      tick();
    end
    chk("stall_done", {SETUP_MODE, setup_done, ant_id}, {1'b0, 1'b1, 2'd0});

    // Steps with period 10, snapshot, run_en drop
    run_en = 1'b1;
    tick();
    chk("run_entry", {newLocClock, write_flag, step_count}, 18'd0);
    wait_nlc(40, 10, "first_step");
    check_sweep(c_AX, c_AY, 0);
    chk("step_count1", step_count, 16'd1);
    wait_nlc(40, 10, "period_step");
    ax_alt = Ant_X;
    check_sweep(c_AX, c_AY, 1);
    chk("step_count2", step_count, 16'd2);
    wait_nlc(40, 10, "after_change");
    check_sweep(~ax_alt, c_AY, 2);
    Ant_X = c_AX;
    seen = 0;
    for (int s = 0; s < 20; s++) begin
      tick();
      if (newLocClock || write_flag) seen++;
    end
    chk("hold_low", seen[15:0], 16'd0);
    run_en = 1'b1;
    repeat (4) tick();
    run_en = 1'b0;
    repeat (10) tick();
    run_en = 1'b1;
    wait_nlc(40, 6, "resume_counter");
    check_sweep(c_AX, c_AY, 0);
    step_period = 16'd0;
    wait_nlc(40, 1, "period_zero_a");
    check_sweep(c_AX, c_AY, 0);
    wait_nlc(40, 1, "period_zero_b");
    check_sweep(c_AX, c_AY, 0);
    chk("step_count6", step_count, 16'd6);

    // Reset during CFG_LOAD
    run_en = 1'b0;
    start_setup = 1'b1;
    tick();
    start_setup = 1'b0;
    chk("setup_from_run", {cfg_ready, SETUP_MODE, ant_id, step_count}, {1'b1, 1'b1, 2'd0, 16'd6});
    cfg_valid = 1'b1;
    cfg_data  = 16'hBEEF;
    tick();
    chk("in_cfg_load", setup_clk, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_in_load", all_outs(), 64'd0);
    cfg_valid = 1'b0;
    #2 rst_n = 1'b1;
    start_setup = 1'b1;
    tick();
    start_setup = 1'b0;
    chk("restart_setup", {cfg_ready, SETUP_MODE, ant_id, setup_done}, {1'b1, 1'b1, 2'd0, 1'b0});

    // Reset during WRITE
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    quick_setup();
    step_period = 16'd1;
    run_en = 1'b1;
    tick();
    wait_nlc(40, 1, "pre_write_reset");
    tick();
    tick();
    chk("in_write", write_flag, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_in_write", all_outs(), 64'd0);
    #2 rst_n = 1'b1;

    // step_count wrap
    quick_setup();
    tick();
    force dut.r_step_count = 16'hFFFF;
    #2 release dut.r_step_count;
    chk("forced_count", step_count, 16'hFFFF);
    wait_nlc(40, 1, "wrap_step");
    check_sweep(c_AX, c_AY, 0);
    chk("count_wrap", step_count, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
